// File: rtl/drop_tick_if.sv
`default_nettype none
// ============================================================================
// Module   : drop_tick_if
// Purpose  : Control/status bundle between the game core and the gravity
//            scheduler.
//   start       pulse, leaves IDLE
//   stop        pulse, back to IDLE from any state
//   pause       pulse, toggles pause
//   level[3:0]  game level 0..15
//   soft_drop   level, soft-drop request
//   landed      level, piece cannot move down
//   move_reset  pulse, piece shifted or rotated
//   drop_pulse  one-cycle gravity step
//   lock_pulse  one-cycle lock commit
//   state[1:0]  0=IDLE 1=FALL 2=LOCK_WAIT 3=PAUSED
// Modports : master drives the requests, slave (the scheduler) drives status.
// Revision : 1.0 - initial release
// ============================================================================
interface drop_tick_if;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] level;
  logic       soft_drop;
  logic       landed;
  logic       move_reset;
  logic       drop_pulse;
  logic       lock_pulse;
  logic [1:0] state;

  modport master (
    output start, stop, pause, level, soft_drop, landed, move_reset,
    input  drop_pulse, lock_pulse, state
  );

  modport slave (
    input  start, stop, pause, level, soft_drop, landed, move_reset,
    output drop_pulse, lock_pulse, state
  );
endinterface
`default_nettype wire

// File: rtl/drop_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : drop_tick_scheduler
// Purpose  : Gravity timing controller for the falling piece. A 1 ms
//            prescaler feeds an FSM that issues registered one-cycle
//            drop_pulse / lock_pulse enables with level-dependent speed,
//            soft drop, lock delay and pause.
// Ports    : origin_clk  system clock
//            rst         synchronous active-high reset
//            bus         drop_tick_if.slave (requests in, pulses/state out)
// Options  : LOCK_RESET_LIMIT_EN - when defined, at most 15 move_reset
//            pulses per piece restart the lock delay.
// Revision : 1.0 - initial release
// ============================================================================
module drop_tick_scheduler #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BASE_MS = 800,
  parameter int STEP_MS = 50,
  parameter int MIN_MS  = 100,
  parameter int SOFT_MS = 50,
  parameter int LOCK_MS = 500
) (
  input  wire logic  origin_clk,
  input  wire logic  rst,
  drop_tick_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_FALL      = 2'd1,
    S_LOCK_WAIT = 2'd2,
    S_PAUSED    = 2'd3
  } state_t;

  localparam int              C_PRESC_MAX  = CLK_HZ / 1000 - 1;
  localparam int              C_PRESC_W    = (C_PRESC_MAX > 0) ? $clog2(C_PRESC_MAX + 1) : 1;
  localparam logic [C_PRESC_W-1:0] C_PRESC_TERM = C_PRESC_W'(C_PRESC_MAX);
  localparam logic [15:0]     C_BASE       = 16'(BASE_MS);
  localparam logic [15:0]     C_STEP       = 16'(STEP_MS);
  localparam logic [15:0]     C_MIN        = 16'(MIN_MS);
  localparam logic [15:0]     C_SOFT       = 16'(SOFT_MS);
  localparam logic [15:0]     C_LOCK       = 16'(LOCK_MS);

  state_t                 r_state, w_state_n;
  state_t                 r_saved, w_saved_n;
  logic [C_PRESC_W-1:0]   r_presc, w_presc_n;
  logic [15:0]            r_ms_cnt, w_ms_cnt_n;
  logic [15:0]            r_lock_cnt, w_lock_cnt_n;
  logic                   r_drop, w_drop_n;
  logic                   r_lock, w_lock_n;
  logic                   w_tick;
  logic [15:0]            w_reduce;
  logic [15:0]            w_grav;
  logic [15:0]            w_period;
  logic                   w_mr_ok;
  logic                   w_mr_clr;
  logic                   w_mr_inc;

  // Prescaler only advances while the game is actively running.
  assign w_tick = ((r_state == S_FALL) || (r_state == S_LOCK_WAIT)) &&
                  (r_presc == C_PRESC_TERM);

  // Saturating gravity period: compare against the floor before subtracting
  // so a high level never wraps below zero.
  assign w_reduce = 16'(bus.level) * C_STEP;
  assign w_grav   = (C_BASE > (w_reduce + C_MIN)) ? (C_BASE - w_reduce) : C_MIN;
  assign w_period = (bus.soft_drop && (C_SOFT < w_grav)) ? C_SOFT : w_grav;

`ifdef LOCK_RESET_LIMIT_EN
  logic [3:0] r_mr_cnt;

  // Once 15 resets have been spent on this piece, further move_reset
  // pulses fall through to the normal tick handling.
  assign w_mr_ok = bus.move_reset && (r_mr_cnt != 4'd15);

  always_ff @(posedge origin_clk) begin
    if (rst || w_mr_clr) begin
      r_mr_cnt <= 4'd0;
    end else if (w_mr_inc) begin
      r_mr_cnt <= r_mr_cnt + 4'd1;
    end
  end
`else
  logic w_unused_mr;

  assign w_mr_ok     = bus.move_reset;
  assign w_unused_mr = w_mr_clr ^ w_mr_inc;
`endif

  always_comb begin
    w_state_n    = r_state;
    w_saved_n    = r_saved;
    w_presc_n    = r_presc;
    w_ms_cnt_n   = r_ms_cnt;
    w_lock_cnt_n = r_lock_cnt;
    w_drop_n     = 1'b0;
    w_lock_n     = 1'b0;
    w_mr_clr     = 1'b0;
    w_mr_inc     = 1'b0;

    if (bus.stop) begin
      // Game over: like reset, but the saved pause target is kept.
      w_state_n    = S_IDLE;
      w_presc_n    = '0;
      w_ms_cnt_n   = '0;
      w_lock_cnt_n = '0;
      w_mr_clr     = 1'b1;
    end else if (bus.pause && (r_state != S_IDLE)) begin
      // Pause cycle freezes every counter, so a tick due now is deferred,
      // not lost.
      if (r_state == S_PAUSED) begin
        w_state_n = r_saved;
      end else begin
        w_saved_n = r_state;
        w_state_n = S_PAUSED;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          w_presc_n = '0;
          if (bus.start) begin
            w_state_n    = S_FALL;
            w_ms_cnt_n   = '0;
            w_lock_cnt_n = '0;
          end
        end
        S_FALL: begin
          w_presc_n = w_tick ? '0 : r_presc + C_PRESC_W'(1);
          if (bus.landed) begin
            w_state_n    = S_LOCK_WAIT;
            w_lock_cnt_n = '0;
          end else if (w_tick) begin
            // >= lets a period that shrank mid-count fire on this tick.
            if ((r_ms_cnt + 16'd1) >= w_period) begin
              w_drop_n   = 1'b1;
              w_ms_cnt_n = '0;
            end else begin
              w_ms_cnt_n = r_ms_cnt + 16'd1;
            end
          end
        end
        S_LOCK_WAIT: begin
          w_presc_n = w_tick ? '0 : r_presc + C_PRESC_W'(1);
          if (!bus.landed) begin
            w_state_n  = S_FALL;
            w_ms_cnt_n = '0;
          end else if (w_mr_ok) begin
            // A move beats a same-cycle lock deadline.
            w_lock_cnt_n = '0;
            w_mr_inc     = 1'b1;
          end else if (w_tick) begin
            if ((r_lock_cnt + 16'd1) >= C_LOCK) begin
              w_lock_n     = 1'b1;
              w_state_n    = S_FALL;
              w_ms_cnt_n   = '0;
              w_lock_cnt_n = '0;
              w_mr_clr     = 1'b1;
            end else begin
              w_lock_cnt_n = r_lock_cnt + 16'd1;
            end
          end
        end
        default: begin
          // PAUSED: everything held until the next pause pulse.
        end
      endcase
    end
  end

  always_ff @(posedge origin_clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_saved    <= S_FALL;
      r_presc    <= '0;
      r_ms_cnt   <= '0;
      r_lock_cnt <= '0;
      r_drop     <= 1'b0;
      r_lock     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_saved    <= w_saved_n;
      r_presc    <= w_presc_n;
      r_ms_cnt   <= w_ms_cnt_n;
      r_lock_cnt <= w_lock_cnt_n;
      r_drop     <= w_drop_n;
      r_lock     <= w_lock_n;
    end
  end

  assign bus.drop_pulse = r_drop;
  assign bus.lock_pulse = r_lock;
  assign bus.state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_drop_tick_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_drop_tick_scheduler
// Purpose  : Self-checking bench for drop_tick_scheduler at 4 cycles/ms.
//            Directed timing scenarios followed by a randomized run, all
//            compared every cycle against a millisecond-level model.
// Ports    : none (top level)
// Revision : 1.0 - initial release
// ============================================================================
module tb_drop_tick_scheduler;

  localparam int CLK_HZ  = 4000;
  localparam int CPM     = CLK_HZ / 1000;
  localparam int BASE_MS = 800;
  localparam int STEP_MS = 50;
  localparam int MIN_MS  = 100;
  localparam int SOFT_MS = 50;
  localparam int LOCK_MS = 500;
`ifdef LOCK_RESET_LIMIT_EN
  localparam int MAX_RESETS = 15;
`else
  localparam int MAX_RESETS = 1 << 30;
`endif

  logic origin_clk = 1'b0;
  logic rst        = 1'b0;

  drop_tick_if bus ();

  drop_tick_scheduler #(
    .CLK_HZ (CLK_HZ),
    .BASE_MS(BASE_MS),
    .STEP_MS(STEP_MS),
    .MIN_MS (MIN_MS),
    .SOFT_MS(SOFT_MS),
    .LOCK_MS(LOCK_MS)
  ) dut (
    .origin_clk(origin_clk),
    .rst       (rst),
    .bus       (bus)
  );

  always #5 origin_clk = ~origin_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: state numbering from the port table, time kept as
  // cycles-into-current-ms plus whole milliseconds elapsed.
  int m_state  = 0;
  int m_saved  = 1;
  int m_sub    = 0;
  int m_ms     = 0;
  int m_lockms = 0;
  int m_resets = 0;
  int m_drop   = 0;
  int m_lockp  = 0;

  function automatic int period_ms(input int lv, input bit sd);
    int g;
    g = BASE_MS - lv * STEP_MS;
    if (g < MIN_MS) g = MIN_MS;
    if (sd && SOFT_MS < g) g = SOFT_MS;
    return g;
  endfunction

  task automatic model_update(input bit rs, input bit st, input bit sp, input bit ps,
                              input bit mr, input int lv, input bit sd, input bit ld);
    bit ms_done;
    m_drop  = 0;
    m_lockp = 0;
    if (rs) begin
      m_state = 0; m_saved = 1; m_sub = 0; m_ms = 0; m_lockms = 0; m_resets = 0;
    end else if (sp) begin
      m_state = 0; m_sub = 0; m_ms = 0; m_lockms = 0; m_resets = 0;
    end else if (ps && m_state != 0) begin
      if (m_state == 3) m_state = m_saved;
      else begin m_saved = m_state; m_state = 3; end
    end else if (m_state == 0) begin
      if (st) begin m_state = 1; m_ms = 0; m_lockms = 0; end
    end else if (m_state != 3) begin
      ms_done = (m_sub == CPM - 1);
      m_sub   = ms_done ? 0 : m_sub + 1;
      if (m_state == 1) begin
        if (ld) begin m_state = 2; m_lockms = 0; end
        else if (ms_done) begin
          if (m_ms + 1 >= period_ms(lv, sd)) begin m_drop = 1; m_ms = 0; end
          else m_ms++;
        end
      end else begin
        if (!ld) begin m_state = 1; m_ms = 0; end
        else if (mr && m_resets < MAX_RESETS) begin m_lockms = 0; m_resets++; end
        else if (ms_done) begin
          if (m_lockms + 1 >= LOCK_MS) begin
            m_lockp = 1; m_state = 1; m_ms = 0; m_lockms = 0; m_resets = 0;
          end else m_lockms++;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive requests, let the edge happen, compare at the negedge.
  task automatic step(input bit st, input bit sp, input bit ps, input bit mr, input bit rs);
    bus.start = st; bus.stop = sp; bus.pause = ps; bus.move_reset = mr; rst = rs;
    @(posedge origin_clk);
    model_update(rs, st, sp, ps, mr, int'(bus.level), bus.soft_drop, bus.landed);
    @(negedge origin_clk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.move_reset = 1'b0; rst = 1'b0;
    chk("state", 32'(bus.state), 32'(m_state));
    chk("drop_pulse", 32'(bus.drop_pulse), 32'(m_drop));
    chk("lock_pulse", 32'(bus.lock_pulse), 32'(m_lockp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic run_count(input int n, output int drops, output int locks);
    drops = 0; locks = 0;
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 0, 0);
      if (bus.drop_pulse === 1'b1) drops++;
      if (bus.lock_pulse === 1'b1) locks++;
    end
  endtask

  // Cycles until the chosen pulse shows; -1 if the budget runs out.
  task automatic wait_pulse(input bit want_lock, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(0, 0, 0, 0, 0);
      if ((want_lock ? bus.lock_pulse : bus.drop_pulse) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // Advance so that the next clock edge is a millisecond boundary.
  task automatic align_tick();
    for (int i = 0; i < CPM && m_sub != CPM - 1; i++) step(0, 0, 0, 0, 0);
  endtask

  initial begin
    int n, drops, locks, total, exp_total;
    bus.start = 0; bus.stop = 0; bus.pause = 0; bus.move_reset = 0;
    bus.level = 4'd0; bus.soft_drop = 0; bus.landed = 0;

    @(negedge origin_clk);
    step(0, 0, 0, 0, 1);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_outputs", {30'd0, bus.drop_pulse, bus.lock_pulse}, 32'd0);

    step(0, 0, 1, 0, 0);
    chk("idle_pause_ignored", 32'(bus.state), 32'd0);

    // Level 0 gravity
    step(1, 0, 0, 0, 0);
    wait_pulse(0, 4000, n);  chk("first_drop_latency", n, 3200);
    wait_pulse(0, 4000, n);  chk("drop_period_l0", n, 3200);
    chk("fall_state", 32'(bus.state), 32'd1);

    // Level 15 saturates at the floor
    bus.level = 4'd15;
    wait_pulse(0, 1000, n);  chk("drop_period_l15", n, 400);
    wait_pulse(0, 1000, n);  chk("drop_period_l15_again", n, 400);

    // Soft drop at level 0
    bus.level = 4'd0; bus.soft_drop = 1'b1;
    wait_pulse(0, 1000, n);  chk("drop_period_soft", n, 200);
    wait_pulse(0, 1000, n);  chk("drop_period_soft_again", n, 200);

    // Period shrinking below an accumulated count fires on the next tick
    bus.soft_drop = 1'b0;
    idle(1000);
    bus.soft_drop = 1'b1;
    wait_pulse(0, 16, n);    chk("shrink_fires_next_tick", n, 4);
    bus.soft_drop = 1'b0;

    // Landing and lock delay
    align_tick();
    bus.landed = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("landed_state", 32'(bus.state), 32'd2);
    chk("landed_no_drop", 32'(bus.drop_pulse), 32'd0);
    wait_pulse(1, 2500, n);  chk("lock_delay", n, 2000);
    chk("lock_returns_fall", 32'(bus.state), 32'd1);
    bus.landed = 1'b0;
    step(0, 0, 0, 0, 0);

    // move_reset restarts the lock delay
    align_tick();
    bus.landed = 1'b1;
    step(0, 0, 0, 0, 0);
    idle(999);
    step(0, 0, 0, 1, 0);
    wait_pulse(1, 2500, n);
    total = (n < 0) ? -1 : 1000 + n;
    chk("lock_after_move_reset", total, 3000);
    bus.landed = 1'b0;
    step(0, 0, 0, 0, 0);

    // Lifting off before the deadline cancels the lock
    align_tick();
    bus.landed = 1'b1;
    step(0, 0, 0, 0, 0);
    idle(1000);
    bus.landed = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("unland_state", 32'(bus.state), 32'd1);
    run_count(2500, drops, locks);
    chk("unland_no_lock", locks, 0);

    // Pause halfway through a gravity period
    wait_pulse(0, 4000, n);  chk("sync_drop_seen", 32'(n > 0), 32'd1);
    idle(1600);
    step(0, 0, 1, 0, 0);
    chk("paused_state", 32'(bus.state), 32'd3);
    run_count(5000, drops, locks);
    step(1, 0, 0, 1, 0);
    run_count(5000, n, total);
    chk("paused_no_pulses", drops + locks + n + total, 0);
    chk("still_paused", 32'(bus.state), 32'd3);
    step(0, 0, 1, 0, 0);
    chk("resume_state", 32'(bus.state), 32'd1);
    wait_pulse(0, 2000, n);  chk("drop_after_resume", n, 1600);

    // Pause from LOCK_WAIT comes back to LOCK_WAIT
    bus.landed = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    chk("pause_from_lock_wait", 32'(bus.state), 32'd3);
    step(0, 0, 1, 0, 0);
    chk("resume_to_lock_wait", 32'(bus.state), 32'd2);

    // stop in LOCK_WAIT
    idle(100);
    step(0, 1, 0, 0, 0);
    chk("stop_state", 32'(bus.state), 32'd0);
    bus.landed = 1'b0;
    run_count(500, drops, locks);
    chk("stopped_no_pulses", drops + locks, 0);

    // stop and pause together
    step(1, 0, 0, 0, 0);
    idle(10);
    step(0, 1, 1, 0, 0);
    chk("stop_beats_pause", 32'(bus.state), 32'd0);

    // rst mid-FALL
    step(1, 0, 0, 0, 0);
    idle(50);
    step(0, 0, 0, 0, 1);
    chk("rst_mid_fall", {28'd0, bus.state, bus.drop_pulse, bus.lock_pulse}, 32'd0);

    // Twenty move_reset pulses, 100 cycles apart, in LOCK_WAIT
    step(1, 0, 0, 0, 0);
    align_tick();
    bus.landed = 1'b1;
    step(0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      idle(99);
      step(0, 0, 0, 1, 0);
    end
    wait_pulse(1, 2500, n);
    total = (n < 0) ? -1 : 2000 + n;
`ifdef LOCK_RESET_LIMIT_EN
    exp_total = 1500 + 2000;
`else
    exp_total = 2000 + 2000;
`endif
    chk("lock_after_20_resets", total, exp_total);
    bus.landed = 1'b0;
    step(0, 1, 0, 0, 0);

    // Randomized run against the model
    for (int i = 0; i < 15000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) bus.soft_drop = ~bus.soft_drop;
      if ($urandom_range(0, 799) == 0) bus.landed = ~bus.landed;
      step(bit'($urandom_range(0, 49) == 0), bit'($urandom_range(0, 4999) == 0),
           bit'($urandom_range(0, 1999) == 0), bit'($urandom_range(0, 99) == 0),
           bit'($urandom_range(0, 7999) == 0));
      chk("pulses_exclusive", 32'(bus.drop_pulse & bus.lock_pulse), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/drop_tick_scheduler.md
Name: drop_tick_scheduler

Overview:
- Timing controller for falling-piece gravity in the Tetris core.
- Emits single-cycle enable pulses on the system clock: drop_pulse moves the piece down one row; lock_pulse commits a landed piece.
- Replaces free-running divided clocks with one enable-based scheduler driven by a 1 ms prescaler.
- Adds level-dependent speed, soft drop, lock delay and pause, sequenced by an FSM.

Parameters:
- CLK_HZ, 100000000, system clock frequency; prescaler terminal value is CLK_HZ/1000-1.
- BASE_MS, 800, gravity period at level 0, in ms; must be ≤1023.
- STEP_MS, 50, period reduction per level, in ms.
- MIN_MS, 100, gravity period floor, in ms; must be ≥1.
- SOFT_MS, 50, period while soft_drop is held, in ms.
- LOCK_MS, 500, lock delay, in ms; must be ≤1023.

Ports:
- origin_clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; leaves IDLE.
- stop  in  1  pulse; returns to IDLE from any state (game over).
- pause  in  1  pulse; toggles pause.
- level  in  4  game level, 0..15.
- soft_drop  in  1  level-sensitive soft-drop request.
- landed  in  1  level; piece cannot move down.
- move_reset  in  1  pulse; piece shifted or rotated.
- drop_pulse  out  1  one-cycle gravity step.
- lock_pulse  out  1  one-cycle lock commit.
- state  out  2  0=IDLE, 1=FALL, 2=LOCK_WAIT, 3=PAUSED.

Behaviour:
- Reset (synchronous): state=IDLE; prescaler, ms_cnt and lock_cnt = 0; drop_pulse=0; lock_pulse=0; saved state=FALL.
- Prescaler:
  - Counts 0..CLK_HZ/1000-1 only in FALL and LOCK_WAIT; holds its value in PAUSED; cleared in IDLE.
  - Internal ms_tick is high for one cycle at the terminal count, then the prescaler wraps to 0.
- Gravity period:
  - grav = BASE_MS - level*STEP_MS, saturating at MIN_MS. Compute at ≥11 bits; no underflow.
  - period = soft_drop ? min(SOFT_MS, grav) : grav.
  - Re-evaluated every cycle.
- IDLE: outputs 0. start goes to FALL with all counters cleared.
- FALL:
  - On ms_tick, if ms_cnt+1 ≥ period: drop_pulse=1 for one cycle and ms_cnt←0; otherwise ms_cnt increments.
  - Use ≥, not ==, so a period that shrinks mid-count fires on the next tick.
  - landed=1 goes to LOCK_WAIT with lock_cnt←0. landed takes priority, so no drop_pulse that cycle.
- LOCK_WAIT:
  - No drop_pulse.
  - On ms_tick, lock_cnt increments.
  - When lock_cnt+1 ≥ LOCK_MS on a tick: lock_pulse=1 for one cycle, go to FALL, ms_cnt←0, lock_cnt←0.
  - move_reset clears lock_cnt. It takes priority over a same-cycle lock deadline.
  - landed=0 goes to FALL with ms_cnt←0.
- PAUSED:
  - Entered by pause from FALL or LOCK_WAIT; the state is saved.
  - pause returns to the saved state. Counters are frozen, not cleared.
  - No pulses while paused. Inputs other than pause, stop and rst are ignored.
- Priority: rst > stop > pause > start/landed/move_reset/tick logic. pause in IDLE is ignored.
- Outputs are registered: a pulse appears the cycle after the qualifying ms_tick edge condition. drop_pulse and lock_pulse are never high together.
- stop mid-operation behaves like reset, except rst remains the only way to clear the saved pause state.

Optional Feature:
- Macro LOCK_RESET_LIMIT_EN.
- Defined:
  - A 4-bit reset counter limits move_reset to 15 effective lock-delay resets per piece.
  - The counter clears on lock_pulse, on stop and on rst.
  - The 16th and later move_reset pulses are ignored, so lock fires LOCK_MS after the 15th reset.
- Undefined: every move_reset clears lock_cnt, with no limit.

Test Plan (CLK_HZ=4000, i.e. 4 cycles/ms):
- rst, then start, level=0, landed=0 -> first drop_pulse 3200 cycles (800 ms) after start, then every 3200 cycles; state=1.
- level=15 -> grav saturates to MIN_MS, giving a drop every 400 cycles. With soft_drop=1 at level=0 -> a drop every 200 cycles, and the first drop occurs on the next tick where ms_cnt+1 ≥ 50.
- landed=1 in FALL -> state=2 next cycle, no drop_pulse, and lock_pulse 2000 cycles later. move_reset at 1000 cycles -> lock_pulse at 3000 cycles total. landed=0 before the deadline -> state=1 and no lock_pulse.
- pause at 1600 cycles into a 3200-cycle period, hold for 10000 cycles, pause again -> next drop_pulse 1600 cycles after resume; state=3 while paused, with no pulses.
- stop during LOCK_WAIT -> state=0 and no pulses. Same-cycle stop and pause -> IDLE. rst mid-FALL -> all outputs 0 on the next cycle.
- With LOCK_RESET_LIMIT_EN: 20 move_reset pulses, 100 cycles apart, in LOCK_WAIT -> lock_pulse 2000 cycles after the 15th. Without the macro -> lock_pulse 2000 cycles after the 20th.
